// File: rtl/wb_multibank_ram.sv
// Multi-port Wishbone RAM: NUM_PORTS pipelined slave ports share NUM_BANKS
// byte-writable single-port banks, each with its own round-robin arbiter.
module wb_multibank_ram #(
   parameter int NUM_PORTS = 4,
   parameter int NUM_BANKS = 4,
   parameter int A_WIDTH   = 8,
   parameter int D_WIDTH   = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              port_wb_stb_i,
   input  logic [NUM_PORTS*(A_WIDTH+$clog2(NUM_BANKS))-1:0] port_wb_addr_i,
   input  logic [NUM_PORTS*(D_WIDTH/8)-1:0]  port_wb_we_i,
   input  logic [NUM_PORTS*D_WIDTH-1:0]      port_wb_data_i,
   output logic [NUM_PORTS-1:0]              port_wb_ack_o,
   output logic [NUM_PORTS-1:0]              port_wb_stall_o,
   output logic [NUM_PORTS*D_WIDTH-1:0]      port_wb_data_o
);

   localparam int BW    = $clog2(NUM_BANKS);
   localparam int PA    = A_WIDTH + BW;
   localparam int NB    = D_WIDTH / 8;
   localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int DEPTH = 2 ** A_WIDTH;

   logic [BW-1:0]      port_sel   [NUM_PORTS];
   logic [A_WIDTH-1:0] port_addr  [NUM_PORTS];
   logic [NB-1:0]      port_we    [NUM_PORTS];
   logic [D_WIDTH-1:0] port_wdata [NUM_PORTS];

   logic [PW-1:0]      last       [NUM_BANKS];
   logic [PW-1:0]      win        [NUM_BANKS];
   logic [NUM_BANKS-1:0] bank_en;
   logic [NUM_PORTS-1:0] granted;

   logic [A_WIDTH-1:0] bank_addr  [NUM_BANKS];
   logic [NB-1:0]      bank_we    [NUM_BANKS];
   logic [D_WIDTH-1:0] bank_wdata [NUM_BANKS];
   logic [D_WIDTH-1:0] bank_rdata [NUM_BANKS];

   logic [D_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_addr[p]  = port_wb_addr_i[p*PA +: A_WIDTH];
         port_sel[p]   = port_wb_addr_i[p*PA + A_WIDTH +: BW];
         port_we[p]    = port_wb_we_i[p*NB +: NB];
         port_wdata[p] = port_wb_data_i[p*D_WIDTH +: D_WIDTH];
      end
   end

   // Scan starts just after the last winner, so the last winner has lowest priority.
   always_comb begin : arb
      int idx;
      idx     = 0;
      granted = '0;
      bank_en = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         win[b] = '0;
         for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last[b]) + k;
            if (idx >= NUM_PORTS)
               idx = idx - NUM_PORTS;
            if (!rst && !bank_en[b] && port_wb_stb_i[idx] && (port_sel[idx] == BW'(b))) begin
               bank_en[b]   = 1'b1;
               win[b]       = PW'(idx);
               granted[idx] = 1'b1;
            end
         end
      end
   end

   assign port_wb_stall_o = rst ? '0 : (port_wb_stb_i & ~granted);

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_addr[b]  = port_addr[win[b]];
         bank_we[b]    = port_we[win[b]];
         bank_wdata[b] = port_wdata[win[b]];
         bank_rdata[b] = mem[b][bank_addr[b]];
      end
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_en[b]) begin
            for (int i = 0; i < NB; i++) begin
               if (bank_we[b][i])
                  mem[b][bank_addr[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
            end
         end
      end
   end

   // A granted port is the sole user of its bank, so bank_rdata is its own read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++)
            last[b] <= PW'(NUM_PORTS - 1);
         port_wb_ack_o  <= '0;
         port_wb_data_o <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_en[b])
               last[b] <= win[b];
         end
         for (int p = 0; p < NUM_PORTS; p++) begin
            port_wb_ack_o[p] <= granted[p];
            if (granted[p] && (port_we[p] == '0))
               port_wb_data_o[p*D_WIDTH +: D_WIDTH] <= bank_rdata[port_sel[p]];
         end
      end
   end

endmodule

// File: doc/wb_multibank_ram.md
Name: wb_multibank_ram

Overview:
- Parametrised successor to the two-port/two-bank Wishbone RAM block: NUM_PORTS pipelined Wishbone slave ports share NUM_BANKS internal single-port byte-writable RAM banks.
- Each bank has an independent round-robin arbiter. Ports hitting different banks proceed in parallel; losing ports see stall.
- Unlike the previous generation, ack is registered and aligned with read data, and fairness is N-way rather than a single toggle.

Parameters:
- NUM_PORTS, 4, number of Wishbone slave ports (>=1).
- NUM_BANKS, 4, number of RAM banks; power of 2, >=2.
- A_WIDTH, 8, word-address width inside one bank (depth 2**A_WIDTH).
- D_WIDTH, 32, data width; multiple of 8.
- BW, $clog2(NUM_BANKS), bank-select width (localparam).
- PA, A_WIDTH+BW, per-port address width (localparam).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- port_wb_stb_i  in  NUM_PORTS  per-port strobe (request valid)
- port_wb_addr_i  in  NUM_PORTS*PA  per-port word address, port p at [p*PA +: PA]; bits [PA-1:A_WIDTH] select the bank
- port_wb_we_i  in  NUM_PORTS*(D_WIDTH/8)  per-port byte write enables; all zero means read
- port_wb_data_i  in  NUM_PORTS*D_WIDTH  per-port write data
- port_wb_ack_o  out  NUM_PORTS  per-port acknowledge (registered)
- port_wb_stall_o  out  NUM_PORTS  per-port stall (combinational)
- port_wb_data_o  out  NUM_PORTS*D_WIDTH  per-port read data (registered)

Behaviour:
- Bank b request vector: req_b[p] = stb[p] && (bank_sel[p] == b).
- Arbiter per bank holds last_b (index of last granted port).
  - Grant goes to the first requesting port scanning last_b+1, last_b+2, ... modulo NUM_PORTS.
  - last_b updates to the granted port on every grant; it holds when the bank is idle.
- Each port requests exactly one bank, so at most one grant per port per cycle.
- stall[p] = stb[p] && !granted[p], same cycle, combinational from inputs and arbiter state. stall never asserts without stb.
- Granted access (cycle T):
  - The bank is enabled with the port's low A_WIDTH address bits, we and data.
  - Byte lane i is written iff we[i]; all-zero we is a pure read.
- Cycle T+1:
  - ack[p]=1 for exactly one cycle.
  - For a read, data_o[p] = the word stored at T (before any write at T).
  - For a write, data_o[p] holds its previous value.
- Latency is 1 cycle.
- Pipelined: a port that keeps stb high and is granted every cycle receives back-to-back acks; throughput 1 access/cycle/bank.
- A stalled master holds stb/addr/we/data stable; the block has no queue and no retained request state.
- Read-after-write to the same address by any ports in consecutive cycles returns the new data.
- Simultaneous same-bank requests from k ports: each is served within k cycles (round-robin bound). No starvation while requests persist.
- Ports in different banks are never stalled by each other.
- Reset:
  - ack=0, data_o=0 for all ports.
  - All last_b = NUM_PORTS-1, so port 0 has first priority after reset.
  - stall is forced 0 while rst is high, and no bank is enabled.
  - A grant issued in the cycle before rst asserts produces no ack after reset.
  - RAM contents are not reset.
- Out-of-range cases do not exist: all PA-bit addresses map to a bank.

Test Plan:
- Reset, then port0 writes 0xDEADBEEF to addr 0x005 (we=4'hF); next cycle port0 reads 0x005 -> ack 1 cycle after each grant, read data_o=0xDEADBEEF, stall never asserted.
- Ports 0..3 read simultaneously from banks 0,1,2,3 (addr 0x0xx,0x1xx,0x2xx,0x3xx) -> all granted same cycle, 4 acks next cycle, no stalls.
- Ports 0..3 hold reads to bank 2 for 8 cycles -> grants rotate 0,1,2,3,0,1,2,3; each port stalls exactly 3 of every 4 cycles; acks follow grants by 1 cycle.
- Pre-load 0x11223344 at 0x010; port1 writes we=4'b0101 data 0xAABBCCDD -> subsequent read returns 0x11BB33DD.
- Port0 writes 0x12345678 to 0x020 in cycle T; port3 reads 0x020 in cycle T+1 -> port3 data_o=0x12345678 at T+2.
- Assert rst for 1 cycle while ports 0 and 1 contend on bank 0 with port1 last granted -> no ack the cycle after reset; first post-reset grant goes to port 0.
